// File: rtl/inv_sub_byte_seq_if.sv
// Handshake bundle for the iterative InvSubBytes stage: input block with
// valid/ready towards upstream, output block with valid/ready towards downstream.
interface inv_sub_byte_seq_if;
    logic [127:0] state_in;
    logic         valid_in;
    logic         in_ready;
    logic [127:0] state_out;
    logic         valid_out;
    logic         out_ready;

    modport slave (
        input  state_in,
        input  valid_in,
        input  out_ready,
        output in_ready,
        output state_out,
        output valid_out
    );

    modport master (
        output state_in,
        output valid_in,
        output out_ready,
        input  in_ready,
        input  state_out,
        input  valid_out
    );
endinterface

// File: rtl/inv_sub_byte_seq.sv
// Iterative AES InvSubBytes: BPC shared inverse S-box lanes walk the 16 state
// bytes over 16/BPC cycles, lowest lanes first, behind valid/ready handshakes.

module inv_sbox (
    input  logic [7:0] sub_i,
    output logic [7:0] sub_o
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign sub_o = INV_SBOX[sub_i];
endmodule

module inv_sub_byte_seq #(
    parameter int BPC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_sub_byte_seq_if.slave    bus
);
    localparam int NGRP = 16 / BPC;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_t;

    fsm_t           fsm_q, fsm_d;
    logic [GW-1:0]  grp_q, grp_d;
    logic [127:0]   work_q, work_d;
    logic           in_ready_c;

    logic [3:0]     lane_idx [BPC];
    logic [7:0]     sub_in   [BPC];
    logic [7:0]     sub_out  [BPC];

    // Lane gi of the shared S-box bank serves byte grp*BPC+gi this cycle.
    for (genvar gi = 0; gi < BPC; gi++) begin : g_lane
        assign lane_idx[gi] = 4'(32'(grp_q) * BPC + gi);
        assign sub_in[gi]   = work_q[{lane_idx[gi], 3'b000} +: 8];

        inv_sbox u_sbox (
            .sub_i (sub_in[gi]),
            .sub_o (sub_out[gi])
        );
    end

    always_comb begin
        fsm_d      = fsm_q;
        grp_d      = grp_q;
        work_d     = work_q;
        in_ready_c = 1'b0;

        case (fsm_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.valid_in) begin
                    work_d = bus.state_in;
                    grp_d  = '0;
                    fsm_d  = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < BPC; k++) begin
                    work_d[{lane_idx[k], 3'b000} +: 8] = sub_out[k];
                end
                if (grp_q == GW'(NGRP - 1)) begin
                    grp_d = '0;
                    fsm_d = DONE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                // Consuming the result and accepting the next block share one edge.
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.valid_in) begin
                        work_d = bus.state_in;
                        grp_d  = '0;
                        fsm_d  = BUSY;
                    end else begin
                        fsm_d  = IDLE;
                    end
                end
            end
            default: begin
                fsm_d = IDLE;
                grp_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            grp_q  <= '0;
            work_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            grp_q  <= grp_d;
            work_q <= work_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.valid_out = (fsm_q == DONE);
    assign bus.state_out = work_q;
endmodule
